// File: rtl/key_scan_display_pkg.sv
// Lock state encodings, segment glyph constants and glyph selector shared by the display blocks.
// Pure declarations, no logic.
package key_scan_display_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WPR   = 2'd1;
  localparam logic [1:0] S_OPEN  = 2'd2;
  localparam logic [1:0] S_ALARM = 2'd3;

  localparam logic [2:0] SL_N = 3'd0;
  localparam logic [2:0] SL_A = 3'd1;

  localparam logic [6:0] SEG_BLANK  = 7'h00;
  localparam logic [6:0] SEG_MASK   = 7'h01;
  localparam logic [6:0] SEG_CURSOR = 7'h08;

  typedef enum logic [1:0] {
    GLY_BLANK,
    GLY_DIGIT,
    GLY_CURSOR
  } glyph_e;

endpackage

// File: rtl/key_scan_display_hex_to_seg.sv
// 4-bit code to active-high {g,f,e,d,c,b,a} glyph, standard 0-F table.
// Combinational, zero latency, no flow control.
module hex_to_seg (
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (code)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/key_scan_display.sv
// Multiplexed N-digit 7-segment driver for the keypad lock entry buffer; SEG/AN registered, 1 cycle after index/state change.
// No backpressure: keys beyond DIGITS are dropped, CLEAR or leaving entry empties the buffer.
module key_scan_display
  import key_scan_display_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 125,
  parameter int MASK      = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [1:0]                  ST,
  input  logic [2:0]                  ST_L,
  input  logic                        KEY_VALID,
  input  logic [3:0]                  KEY_CODE,
  input  logic                        CLEAR,
  output logic [6:0]                  SEG,
  output logic [DIGITS-1:0]           AN,
  output logic [$clog2(DIGITS+1)-1:0] COUNT
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0]            presc;
  logic                     scan_tick;
  logic [IW-1:0]            scan_idx;
  logic [BW-1:0]            blink_cnt;
  logic                     blink_ph;
  logic [DIGITS-1:0][3:0]   digit_buf;
  logic [CW-1:0]            count;
  logic                     entry_active;
  logic [6:0]               hex_seg;
  glyph_e                   gly_sel;
  logic                     shown;
  logic [6:0]               seg_d;
  logic [DIGITS-1:0]        an_d;

  assign scan_tick    = (presc == PW'(SCAN_DIV - 1));
  assign entry_active = (ST == S_WPR);
  assign COUNT        = count;

  // Timing chain free-runs regardless of lock state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc     <= '0;
      scan_idx  <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      presc <= scan_tick ? '0 : presc + PW'(1);
      if (scan_tick) begin
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  // Newest key lands at position 0; CLEAR beats a simultaneous key.
  always_ff @(posedge CLK) begin
    if (RST || CLEAR || !entry_active) begin
      digit_buf <= '0;
      count     <= '0;
    end else if (KEY_VALID && (count < CW'(DIGITS))) begin
      digit_buf <= {digit_buf[DIGITS-2:0], KEY_CODE};
      count     <= count + CW'(1);
    end
  end

  hex_to_seg u_hex_to_seg (
    .code (digit_buf[scan_idx]),
    .seg  (hex_seg)
  );

  // Alarm-armed entry flashes the whole display with the blink phase.
  always_comb begin
    shown   = entry_active && !((ST_L == SL_A) && !blink_ph);
    gly_sel = GLY_BLANK;
    if (CW'(scan_idx) < count) begin
      gly_sel = GLY_DIGIT;
    end else if ((CW'(scan_idx) == count) && blink_ph) begin
      gly_sel = GLY_CURSOR;
    end
  end

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    if (shown) begin
      an_d = ~(DIGITS'(1) << scan_idx);
      case (gly_sel)
        GLY_DIGIT:  seg_d = (MASK != 0) ? SEG_MASK : hex_seg;
        GLY_CURSOR: seg_d = SEG_CURSOR;
        default:    seg_d = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SEG <= SEG_BLANK;
      AN  <= '1;
    end else begin
      SEG <= seg_d;
      AN  <= an_d;
    end
  end

endmodule

// File: tb/tb_key_scan_display.sv
// Scoreboard bench for key_scan_display: two instances (masked and hex glyphs) share stimulus.
// DIGITS=4, SCAN_DIV=4, BLINK_DIV=2: digit k of the scan is presented on edge 4k+1 after reset release.
module tb_key_scan_display;
  import key_scan_display_pkg::*;

  logic       CLK;
  logic       RST;
  logic [1:0] ST;
  logic [2:0] ST_L;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       CLEAR;
  logic [6:0] seg_m, seg_h;
  logic [3:0] an_m, an_h;
  logic [2:0] cnt_m, cnt_h;

  key_scan_display #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .MASK(1)) u_dut (
    .CLK(CLK), .RST(RST), .ST(ST), .ST_L(ST_L), .KEY_VALID(KEY_VALID),
    .KEY_CODE(KEY_CODE), .CLEAR(CLEAR), .SEG(seg_m), .AN(an_m), .COUNT(cnt_m)
  );

  key_scan_display #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .MASK(0)) u_dut_hex (
    .CLK(CLK), .RST(RST), .ST(ST), .ST_L(ST_L), .KEY_VALID(KEY_VALID),
    .KEY_CODE(KEY_CODE), .CLEAR(CLEAR), .SEG(seg_h), .AN(an_h), .COUNT(cnt_h)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         tag;
    bit         any_pos;
    bit         hex;
    bit         chk_glyph;
    int         pos;
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Edges since reset release; presentation of scan slot k happens on edge 4k+1.
  always @(posedge CLK) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge CLK) begin
    exp_t       e;
    logic [6:0] s;
    logic [3:0] a;
    logic [2:0] n;
    bit         pres;
    int         idx;
    if (sb.size() != 0) begin
      e    = sb[0];
      pres = !RST && (cyc % 4 == 1);
      idx  = (cyc / 4) % 4;
      if (e.any_pos || (pres && idx == e.pos)) begin
        void'(sb.pop_front());
        s = e.hex ? seg_h : seg_m;
        a = e.hex ? an_h  : an_m;
        n = e.hex ? cnt_h : cnt_m;
        checks++;
        if (n !== e.cnt || (e.chk_glyph && (s !== e.seg || a !== e.an))) begin
          failures++;
          $display("FAIL step%0d pos%0d hex=%0d: got seg=%h an=%b count=%0d, want seg=%h an=%b count=%0d (glyph checked=%0d)",
                   e.tag, e.pos, e.hex, s, a, n, e.seg, e.an, e.cnt, e.chk_glyph);
        end
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic push(input int tag, input bit any_pos, input bit hex, input bit glyph,
                      input int pos, input logic [6:0] seg, input logic [3:0] an,
                      input logic [2:0] cnt);
    exp_t e;
    e.tag = tag; e.any_pos = any_pos; e.hex = hex; e.chk_glyph = glyph;
    e.pos = pos; e.seg = seg; e.an = an; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // segs = {pos3,pos2,pos1,pos0}; off marks positions expected fully blank (AN all high).
  task automatic frame(input int tag, input bit hex, input logic [2:0] cnt,
                       input logic [27:0] segs, input logic [3:0] off);
    logic [3:0] an;
    for (int p = 0; p < 4; p++) begin
      an = off[p] ? 4'b1111 : ~(4'b0001 << p);
      push(tag, 1'b0, hex, 1'b1, p, segs[p*7 +: 7], an, cnt);
    end
  endtask

  task automatic wait_empty(input int tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge CLK);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL step%0d timeout: got %0d pending entries, want 0", tag, sb.size());
      sb.delete();
    end
    step();
  endtask

  task automatic key(input logic [3:0] k);
    KEY_CODE  = k;
    KEY_VALID = 1'b1;
    step();
    KEY_VALID = 1'b0;
  endtask

  initial begin
    RST = 1'b1; ST = S_IDLE; ST_L = SL_N;
    KEY_VALID = 1'b0; KEY_CODE = 4'h0; CLEAR = 1'b0;

    // Reset held two cycles.
    push(1, 1'b1, 1'b0, 1'b1, 0, 7'h00, 4'b1111, 3'd0);
    push(2, 1'b1, 1'b1, 1'b1, 0, 7'h00, 4'b1111, 3'd0);
    step(); step();
    wait_empty(2);
    RST = 1'b0;
    ST  = S_WPR;

    // Normal entry, keys 3,7: cursor at position 2 (blink phase is 1 on slots 2,3 with these dividers).
    step();
    key(4'h3); key(4'h7);
    step(); step();
    push(3, 1'b1, 1'b0, 1'b0, 0, 7'h00, 4'hF, 3'd2);
    frame(4, 1'b0, 3'd2, {7'h00, 7'h08, 7'h01, 7'h01}, 4'b0000);
    frame(5, 1'b1, 3'd2, {7'h00, 7'h08, 7'h4F, 7'h07}, 4'b0000);
    wait_empty(5);

    // CLEAR and KEY_VALID together: clear wins.
    CLEAR = 1'b1; KEY_VALID = 1'b1; KEY_CODE = 4'h9;
    push(6, 1'b1, 1'b0, 1'b0, 0, 7'h00, 4'hF, 3'd0);
    step();
    CLEAR = 1'b0; KEY_VALID = 1'b0;
    frame(7, 1'b0, 3'd0, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b0000);
    wait_empty(7);

    // Five keys: fifth dropped, buffer full, no cursor.
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h5);
    step(); step();
    frame(8, 1'b1, 3'd4, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000);
    frame(9, 1'b0, 3'd4, {7'h01, 7'h01, 7'h01, 7'h01}, 4'b0000);
    wait_empty(9);

    // Three keys then leave entry.
    CLEAR = 1'b1; step(); CLEAR = 1'b0;
    key(4'hA); key(4'hB); key(4'hC);
    step(); step();
    frame(10, 1'b1, 3'd3, {7'h08, 7'h77, 7'h7C, 7'h39}, 4'b0000);
    wait_empty(10);
    ST = S_IDLE;
    push(11, 1'b1, 1'b0, 1'b0, 0, 7'h00, 4'hF, 3'd0);
    push(12, 1'b1, 1'b0, 1'b1, 0, 7'h00, 4'b1111, 3'd0);
    wait_empty(12);
    frame(13, 1'b0, 3'd0, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b1111);
    wait_empty(13);

    // Alarm-armed entry: slots 0,1 fall in blink phase 0 and go dark.
    ST = S_WPR; ST_L = SL_A;
    step();
    key(4'h9);
    step(); step();
    frame(14, 1'b0, 3'd1, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b0011);
    wait_empty(14);
    key(4'h5); key(4'h6);
    step(); step();
    frame(15, 1'b1, 3'd3, {7'h08, 7'h6F, 7'h00, 7'h00}, 4'b0011);
    frame(16, 1'b0, 3'd3, {7'h08, 7'h01, 7'h00, 7'h00}, 4'b0011);
    wait_empty(16);
    ST_L = SL_N;
    step();
    frame(17, 1'b1, 3'd3, {7'h08, 7'h6F, 7'h6D, 7'h7D}, 4'b0000);
    wait_empty(17);

    // Reset mid-scan: blank next edge, scan restarts at position 0.
    RST = 1'b1;
    push(18, 1'b1, 1'b0, 1'b1, 0, 7'h00, 4'b1111, 3'd0);
    step();
    RST = 1'b0;
    frame(19, 1'b0, 3'd0, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b0000);
    frame(20, 1'b1, 3'd0, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b0000);
    wait_empty(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
